// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses the UART receive byte stream into framed memory-write commands and
// issues single-byte writes on a request/acknowledge memory port.
//
// Packet: opcode, addr_lo, addr_hi, len, payload, csum
//   'W' (0x57): len data bytes, each written as it arrives
//   'F' (0x46): one value byte, written len times after the checksum passes
//   len = 0 means 256; csum is the 8-bit sum of opcode..last payload byte.
//
// Ports:
//   sys_clk   - system clock
//   reset     - asynchronous active-high reset
//   rx_done   - byte-complete level from the UART receiver (high many cycles)
//   rx_data   - received byte, valid while rx_done is high
//   mem_addr  - write address
//   mem_wdata - write data
//   mem_we    - write request, held until mem_ack
//   mem_ack   - write accepted this cycle
//   busy      - parser not idle
//   pkt_ok    - one-cycle pulse on successful packet completion
//   pkt_err   - one-cycle pulse on packet abort/failure
//   err_code  - 0 overrun, 1 bad opcode, 2 checksum, 3 timeout (held)
module uart_cmd_decoder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  pkt_ok,
  output logic                  pkt_err,
  output logic [1:0]            err_code
);

  localparam int unsigned    TCW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_FILL  = 8'h46;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, ADDR_HI, LEN, DATA, CSUM, FILL
  } state_t;

  state_t                  state, state_n;
  logic                    rx_done_d;
  logic                    is_fill, fill_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [8:0]              rem, rem_n;
  logic [7:0]              csum, csum_n;
  logic [TCW-1:0]          tcnt, tcnt_n;
  logic                    we_n;
  logic [7:0]              wdata_n;
  logic                    ok_n, err_n;
  logic [1:0]              code_n;

  logic strobe, acked, overrun, timed;

  assign strobe  = rx_done & ~rx_done_d;
  assign acked   = mem_we & mem_ack;
  // A byte arriving while the previous write is still unacknowledged.
  assign overrun = strobe & mem_we & ~mem_ack;
  assign timed   = (state != IDLE) && (state != FILL);
  assign busy    = (state != IDLE);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rx_done_d <= 1'b1;
      is_fill   <= 1'b0;
      mem_addr  <= '0;
      rem       <= '0;
      csum      <= '0;
      tcnt      <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_n;
      rx_done_d <= rx_done;
      is_fill   <= fill_n;
      mem_addr  <= addr_n;
      rem       <= rem_n;
      csum      <= csum_n;
      tcnt      <= tcnt_n;
      mem_we    <= we_n;
      mem_wdata <= wdata_n;
      pkt_ok    <= ok_n;
      pkt_err   <= err_n;
      err_code  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    fill_n  = is_fill;
    addr_n  = mem_addr;
    rem_n   = rem;
    csum_n  = csum;
    tcnt_n  = '0;
    we_n    = mem_we;
    wdata_n = mem_wdata;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = err_code;

    // W ack retires the current byte and steps the address; a data strobe in
    // the same cycle then issues the next byte at the advanced address.
    if (acked && !is_fill) begin
      we_n   = 1'b0;
      addr_n = mem_addr + ADDR_WIDTH'(1);
    end

    unique case (state)
      IDLE: begin
        if (strobe) begin
          if (rx_data == OP_WRITE || rx_data == OP_FILL) begin
            state_n = ADDR_LO;
            fill_n  = (rx_data == OP_FILL);
            csum_n  = rx_data;
          end else begin
            err_n  = 1'b1;
            code_n = ERR_OPCODE;
          end
        end
      end
      ADDR_LO: begin
        if (strobe) begin
          addr_n[7:0] = rx_data;
          csum_n      = csum + rx_data;
          state_n     = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (strobe) begin
          addr_n[15:8] = rx_data;
          csum_n       = csum + rx_data;
          state_n      = LEN;
        end
      end
      LEN: begin
        if (strobe) begin
          rem_n   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          csum_n  = csum + rx_data;
          state_n = DATA;
        end
      end
      DATA: begin
        if (overrun) begin
          err_n   = 1'b1;
          code_n  = ERR_OVERRUN;
          we_n    = 1'b0;
          state_n = IDLE;
        end else if (strobe) begin
          csum_n  = csum + rx_data;
          wdata_n = rx_data;
          if (is_fill) begin
            state_n = CSUM;
          end else begin
            we_n  = 1'b1;
            rem_n = rem - 9'd1;
            if (rem == 9'd1) state_n = CSUM;
          end
        end
      end
      CSUM: begin
        if (overrun) begin
          err_n   = 1'b1;
          code_n  = ERR_OVERRUN;
          we_n    = 1'b0;
          state_n = IDLE;
        end else if (strobe) begin
          if (rx_data != csum) begin
            err_n   = 1'b1;
            code_n  = ERR_CSUM;
            state_n = IDLE;
          end else if (is_fill) begin
            we_n    = 1'b1;
            state_n = FILL;
          end else begin
            ok_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      FILL: begin
        if (acked) begin
          if (rem == 9'd1) begin
            we_n    = 1'b0;
            ok_n    = 1'b1;
            state_n = IDLE;
          end else begin
            rem_n  = rem - 9'd1;
            addr_n = mem_addr + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Strobe cycles clear the counter (tcnt_n default), so a strobe always
    // wins over an expiring timeout.
    if (timed && !strobe) begin
      if (tcnt == TC_LAST) begin
        err_n   = 1'b1;
        code_n  = ERR_TIMEOUT;
        we_n    = 1'b0;
        state_n = IDLE;
      end else begin
        tcnt_n = tcnt + TCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: randomized and directed packets, with a
// packet-level reference model feeding write/event scoreboards that a
// separate monitor drains.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int TO    = 300;
  localparam int EV_OK = 4;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        pkt_ok;
  logic        pkt_err;
  logic [1:0]  err_code;

  int compared   = 0;
  int mismatched = 0;
  int ack_mode   = 0;   // 0 random (bounded latency), 1 always, 2 never
  int we_cycles  = 0;

  logic [7:0]  pkt[$];
  logic [23:0] wr_q[$];
  int          ev_q[$];

  uart_cmd_decoder #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Reference model: expected writes and final event of one whole packet.
  task automatic model_packet();
    logic [7:0]  s;
    logic [15:0] a;
    int unsigned n;
    bit          good;
    if (pkt[0] != 8'h57 && pkt[0] != 8'h46) begin
      ev_q.push_back(1);
      return;
    end
    a = {pkt[2], pkt[1]};
    n = 32'(pkt[3]);
    if (n == 0) n = 256;
    s = '0;
    for (int i = 0; i < pkt.size() - 1; i++) s = s + pkt[i];
    good = (s == pkt[pkt.size() - 1]);
    if (pkt[0] == 8'h57) begin
      for (int unsigned i = 0; i < n; i++) wr_q.push_back({a + 16'(i), pkt[4 + i]});
    end else if (good) begin
      for (int unsigned i = 0; i < n; i++) wr_q.push_back({a + 16'(i), pkt[4]});
    end
    ev_q.push_back(good ? EV_OK : 2);
  endtask

  task automatic build_random();
    int unsigned r, n;
    logic [7:0]  op, len, s;
    logic [15:0] a;
    pkt.delete();
    r = $urandom_range(0, 7);
    if (r == 0) begin
      op = 8'($urandom_range(0, 255));
      if (op == 8'h57 || op == 8'h46) op = 8'h00;
      pkt.push_back(op);
      return;
    end
    op  = (r < 4) ? 8'h57 : 8'h46;
    a   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
    len = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
    n   = (len == 0) ? 256 : 32'(len);
    pkt.push_back(op);
    pkt.push_back(a[7:0]);
    pkt.push_back(a[15:8]);
    pkt.push_back(len);
    if (op == 8'h57) begin
      for (int unsigned i = 0; i < n; i++) pkt.push_back(8'($urandom));
    end else begin
      pkt.push_back(8'($urandom));
    end
    s = '0;
    for (int i = 0; i < pkt.size(); i++) s = s + pkt[i];
    if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
    pkt.push_back(s);
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    @(posedge sys_clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
  endtask

  task automatic release_byte();
    repeat ($urandom_range(2, 4)) @(posedge sys_clk);
    #1 rx_done = 1'b0;
    repeat ($urandom_range(3, 5)) @(posedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe_byte(b);
    release_byte();
  endtask

  // hold_last leaves the final byte strobed but not released.
  task automatic send_pkt(input bit hold_last);
    model_packet();
    for (int i = 0; i < pkt.size() - 1; i++) send_byte(pkt[i]);
    if (hold_last) strobe_byte(pkt[pkt.size() - 1]);
    else           send_byte(pkt[pkt.size() - 1]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || wr_q.size() != 0 || ev_q.size() != 0) && n < 6000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 6000) check("idle_wait_expired", 1'b0, 32'(n), 32'd6000);
    repeat (2) @(negedge sys_clk);
  endtask

  // Memory-side acknowledge driver.
  initial begin
    int hi = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      hi = mem_we ? hi + 1 : 0;
      case (ack_mode)
        0:       mem_ack = (hi >= 3) || ($urandom_range(0, 2) == 0);
        1:       mem_ack = 1'b1;
        default: mem_ack = 1'b0;
      endcase
    end
  end

  // Monitor: drains the scoreboards whenever the DUT presents a write or event.
  logic        prev_we  = 1'b0;
  logic        prev_ack = 1'b0;
  logic [23:0] prev_wr  = '0;
  always @(negedge sys_clk) begin
    int e;
    if (reset) begin
      prev_we  = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (mem_we) we_cycles++;
      if (prev_we && !prev_ack && mem_we)
        check("hold_stable", {mem_addr, mem_wdata} == prev_wr,
              {8'h0, mem_addr, mem_wdata}, {8'h0, prev_wr});
      if (mem_we && mem_ack) begin
        if (wr_q.size() == 0) unexpected("write", {8'h0, mem_addr, mem_wdata});
        else begin
          logic [23:0] w;
          w = wr_q.pop_front();
          check("write", {mem_addr, mem_wdata} == w, {8'h0, mem_addr, mem_wdata}, {8'h0, w});
        end
      end
      if (pkt_ok) begin
        if (ev_q.size() == 0) unexpected("pkt_ok", 32'd1);
        else begin
          e = ev_q.pop_front();
          check("event_ok", e == EV_OK, 32'(EV_OK), 32'(e));
        end
      end
      if (pkt_err) begin
        if (ev_q.size() == 0) unexpected("pkt_err", {30'h0, err_code});
        else begin
          e = ev_q.pop_front();
          check("event_err", e == int'(err_code), {30'h0, err_code}, 32'(e));
        end
      end
      prev_we  = mem_we;
      prev_ack = mem_ack;
      prev_wr  = {mem_addr, mem_wdata};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, n;
    bit          got;
    logic        noise;
    logic [15:0] ea;

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    #3;
    check("reset_outputs",
          {mem_we, pkt_ok, pkt_err, busy, err_code, mem_addr, mem_wdata} == 30'h0,
          {2'b0, mem_we, pkt_ok, pkt_err, busy, err_code, mem_addr, mem_wdata}, 32'h0);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;

    // Write packet, pkt_ok one cycle after the checksum strobe.
    pkt = '{8'h57, 8'h00, 8'h20, 8'h02, 8'hAA, 8'h55, 8'h78};
    send_pkt(1'b1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("w_pkt_ok_timing", pkt_ok && !busy, {30'h0, pkt_ok, busy}, 32'h2);
    release_byte();
    wait_idle();

    // Fill with address wrap, ack tied high: three back-to-back writes.
    ack_mode = 1;
    pkt = '{8'h46, 8'hFE, 8'hFF, 8'h03, 8'h11, 8'h57};
    send_pkt(1'b1);
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      ea = 16'hFFFE + 16'(i);
      check("fill_wrap_write", mem_we && mem_addr == ea && mem_wdata == 8'h11,
            {7'h0, mem_we, mem_addr, mem_wdata}, {8'h1, ea, 8'h11});
    end
    @(negedge sys_clk);
    check("fill_pkt_ok_timing", pkt_ok && !busy && !mem_we,
          {29'h0, pkt_ok, busy, mem_we}, 32'h4);
    release_byte();
    ack_mode = 0;
    wait_idle();

    // Fill with bad checksum: no write request at all.
    we_cycles = 0;
    pkt = '{8'h46, 8'h00, 8'h10, 8'h02, 8'h33, 8'h00};
    send_pkt(1'b0);
    wait_idle();
    check("f_badcsum_no_we", we_cycles == 0, 32'(we_cycles), 32'h0);

    // Write with bad checksum: writes land, then checksum error.
    pkt = '{8'h57, 8'h00, 8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00};
    send_pkt(1'b0);
    wait_idle();

    // Bad opcode, error code held afterwards.
    pkt = '{8'h00};
    send_pkt(1'b0);
    wait_idle();
    repeat (4) @(negedge sys_clk);
    check("err_code_held", err_code == 2'd1, {30'h0, err_code}, 32'h1);

    // Timeout: 57 00 20 then silence.
    ev_q.push_back(3);
    send_byte(8'h57);
    send_byte(8'h00);
    strobe_byte(8'h20);
    @(negedge sys_clk);
    k   = 0;
    got = 1'b0;
    while (k < TO + 20 && !got) begin
      @(negedge sys_clk);
      k++;
      if (k == 3) rx_done = 1'b0;
      if (pkt_err) got = 1'b1;
    end
    check("timeout_at_expiry", got && k == TO + 1, 32'(k), 32'(TO + 1));
    wait_idle();
    pkt = '{8'h57, 8'h34, 8'h12, 8'h01, 8'h5A, 8'hF8};
    send_pkt(1'b0);
    wait_idle();

    // Overrun: second data byte while the first write is unacknowledged.
    ack_mode = 2;
    ev_q.push_back(0);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h02);
    send_byte(8'hAA);
    @(negedge sys_clk);
    check("overrun_pending_write", mem_we && mem_addr == 16'h2000 && mem_wdata == 8'hAA,
          {7'h0, mem_we, mem_addr, mem_wdata}, {8'h1, 16'h2000, 8'hAA});
    strobe_byte(8'h55);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("overrun_abort", pkt_err && err_code == 2'd0 && !mem_we && !busy,
          {27'h0, pkt_err, err_code, mem_we, busy}, 32'h10);
    release_byte();
    ack_mode = 0;
    wait_idle();

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      build_random();
      send_pkt(1'b0);
      wait_idle();
    end

    // Reset mid-fill; rx_done high across reset release.
    pkt = '{8'h46, 8'h00, 8'h30, 8'h00, 8'h77, 8'hED};
    send_pkt(1'b0);
    n = 0;
    while (wr_q.size() > 250 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("fill_progress", wr_q.size() <= 250, 32'(wr_q.size()), 32'd250);
    #2 reset = 1'b1;
    #1 check("reset_async_we", !mem_we && !busy, {30'h0, mem_we, busy}, 32'h0);
    wr_q.delete();
    ev_q.delete();
    rx_data = 8'h00;
    rx_done = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3 reset = 1'b0;
    noise = 1'b0;
    repeat (6) begin
      @(negedge sys_clk);
      noise = noise | pkt_err | pkt_ok | busy;
    end
    check("no_strobe_after_reset", !noise, {31'h0, noise}, 32'h0);
    @(posedge sys_clk);
    #1 rx_done = 1'b0;
    repeat (4) @(posedge sys_clk);

    pkt = '{8'h57, 8'h00, 8'h50, 8'h01, 8'h9C, 8'h44};
    send_pkt(1'b0);
    wait_idle();

    check("scoreboard_drained", wr_q.size() == 0 && ev_q.size() == 0,
          32'(wr_q.size() + ev_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
